// File: rtl/timer_bank.sv
// timer_bank: bank of independent down-counting timer channels.
// Each channel is an IDLE/READY/RUN state machine with a shared PERIOD input,
// per-channel periodic/one-shot mode, registered TICK pulse and BUSY flag.
// Optional feature macro: TIMER_BANK_PRESCALER_EN -- when defined, counters
// advance only on a shared free-running divider strobe (every CLOCK_SIGNALS
// CLK cycles); when undefined every CLK is a step and no divider exists.
module timer_bank #(
  parameter int          CHANNELS      = 4,
  parameter int          WIDTH         = 32,
  parameter logic [31:0] CLOCK_SIGNALS = 32'd10
) (
  input  logic                CLK,
  input  logic                RES,
  input  logic [CHANNELS-1:0] LOAD,
  input  logic [WIDTH-1:0]    PERIOD,
  input  logic [CHANNELS-1:0] MODE,
  input  logic [CHANNELS-1:0] START,
  input  logic [CHANNELS-1:0] STOP,
  output logic [CHANNELS-1:0] TICK,
  output logic [CHANNELS-1:0] BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  // Elaboration-time parameter range guard.
  if ((CHANNELS < 1) || (CHANNELS > 16) || (WIDTH < 2) || (WIDTH > 32) ||
      (CLOCK_SIGNALS < 32'd1)) begin : g_bad_param
    $error("timer_bank: parameter out of range");
  end

  // A zero period is never a valid load, so it is filtered once for all channels.
  logic             w_period_nz;
  logic [WIDTH-1:0] w_period_m1;
  logic             w_step;

  assign w_period_nz = (PERIOD != '0);
  assign w_period_m1 = PERIOD - WIDTH'(1);

`ifdef TIMER_BANK_PRESCALER_EN
  logic [31:0] r_div;
  logic        w_div_wrap;

  assign w_div_wrap = (r_div == (CLOCK_SIGNALS - 32'd1));
  assign w_step     = w_div_wrap;

  // Free-running step divider; only reset clears it so START does not realign it.
  always_ff @(posedge CLK) begin
    if (!RES) begin
      r_div <= 32'd0;
    end else if (w_div_wrap) begin
      r_div <= 32'd0;
    end else begin
      r_div <= r_div + 32'd1;
    end
  end
`else
  assign w_step = 1'b1;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           r_state;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_cnt;
    logic             r_mode;
    logic             r_tick;
    logic             r_busy;
    logic             w_load_ok;
    logic             w_start_ok;

    assign w_load_ok  = LOAD[i] & w_period_nz;
    // STOP wins over START in the same cycle.
    assign w_start_ok = START[i] & ~STOP[i];
    assign TICK[i]    = r_tick;
    assign BUSY[i]    = r_busy;

    // Channel state machine: load/start/stop handling, countdown and expiry.
    // A load while running restarts the count and takes precedence over an
    // expiry in the same cycle, so no TICK is emitted on that edge.
    // BUSY stays high in the cycle of a one-shot TICK and drops one cycle later.
    always_ff @(posedge CLK) begin
      if (!RES) begin
        r_state  <= S_IDLE;
        r_period <= '0;
        r_cnt    <= '0;
        r_mode   <= 1'b0;
        r_tick   <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        r_tick <= 1'b0;
        if (w_load_ok) begin
          r_period <= PERIOD;
          r_mode   <= MODE[i];
        end else begin
          r_period <= r_period;
          r_mode   <= r_mode;
        end
        case (r_state)
          S_IDLE: begin
            if (w_load_ok && w_start_ok) begin
              r_state <= S_RUN;
              r_cnt   <= w_period_m1;
              r_busy  <= 1'b1;
            end else if (w_load_ok) begin
              r_state <= S_READY;
              r_busy  <= 1'b0;
            end else begin
              r_busy  <= 1'b0;
            end
          end
          S_READY: begin
            if (w_start_ok) begin
              r_state <= S_RUN;
              r_cnt   <= w_load_ok ? w_period_m1 : (r_period - WIDTH'(1));
              r_busy  <= 1'b1;
            end else begin
              r_busy  <= 1'b0;
            end
          end
          S_RUN: begin
            if (STOP[i]) begin
              r_state <= S_READY;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end else if (w_load_ok) begin
              r_cnt   <= w_period_m1;
              r_busy  <= 1'b1;
            end else if (w_step) begin
              r_busy <= 1'b1;
              if (r_cnt == '0) begin
                r_tick <= 1'b1;
                if (r_mode) begin
                  r_cnt   <= r_period - WIDTH'(1);
                end else begin
                  r_state <= S_READY;
                end
              end else begin
                r_cnt <= r_cnt - WIDTH'(1);
              end
            end else begin
              r_busy <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL provide parameter CHANNELS, default 4: number of independent timer channels (1..16).
REQ-002 SHALL provide parameter WIDTH, default 32: period/counter width in bits (2..32).
REQ-003 SHALL provide parameter CLOCK_SIGNALS, default 32'd10: CLK cycles per base step when the prescaler is compiled in (>=1).
REQ-004 SHALL provide port CLK  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL provide port RES  input  1  reset, synchronous, active-low.
REQ-006 SHALL provide port LOAD  input  CHANNELS  per-channel load strobe, sampled each CLK.
REQ-007 SHALL provide port PERIOD  input  WIDTH  period value shared by all channels, captured on LOAD.
REQ-008 SHALL provide port MODE  input  CHANNELS  per-channel mode captured on LOAD: 1 = periodic, 0 = one-shot.
REQ-009 SHALL provide port START  input  CHANNELS  per-channel start strobe.
REQ-010 SHALL provide port STOP  input  CHANNELS  per-channel stop strobe.
REQ-011 SHALL provide port TICK  output  CHANNELS  per-channel one-cycle expiry pulse, registered.
REQ-012 SHALL provide port BUSY  output  CHANNELS  per-channel high while the channel is in RUN, registered.

Function
REQ-013 Each channel SHALL hold a state machine with states IDLE (no valid period), READY (period loaded, stopped), RUN.
REQ-014 LOAD with PERIOD != 0 SHALL capture PERIOD and MODE; IDLE->READY, READY stays READY, RUN stays RUN with counter restarted from the new period.
REQ-015 LOAD with PERIOD == 0 SHALL be ignored: state, stored period, mode and counter unchanged.
REQ-016 START SHALL move READY->RUN with counter = period-1; START in IDLE or RUN SHALL be ignored.
REQ-017 STOP SHALL move RUN->READY, clear the counter, suppress any TICK that cycle; STOP in IDLE/READY ignored.
REQ-018 STOP SHALL take priority over START on the same channel in the same cycle.
REQ-019 LOAD and START in the same cycle SHALL load first, then start with the new period (IDLE->RUN directly).
REQ-020 In RUN the counter SHALL decrement once per step; at count 0 on a step TICK SHALL pulse high one CLK cycle.
REQ-021 Without prescaler a step is every CLK; first TICK SHALL be high exactly P cycles after the START-sampling edge, then every P cycles.
REQ-022 Periodic mode SHALL reload period-1 on expiry with no lost cycle; one-shot SHALL go RUN->READY on expiry, BUSY low the cycle after TICK.
REQ-023 Channels SHALL be fully independent; simultaneous TICKs on several channels SHALL all be reported.
REQ-024 PERIOD = 2^WIDTH-1 SHALL be supported without counter overflow; PERIOD = 1 in periodic mode SHALL give TICK high every step.

Reset
REQ-025 RES low at a CLK edge SHALL force all channels to IDLE, clear stored periods, modes, counters, TICK=0, BUSY=0, regardless of other inputs.
REQ-026 Reset asserted mid-RUN SHALL abort without emitting TICK; after RES returns high a LOAD is required before START is accepted.

Configuration
REQ-027 With macro TIMER_BANK_PRESCALER_EN defined, a shared free-running divider SHALL emit a step strobe once every CLOCK_SIGNALS CLK cycles and counters SHALL decrement only on that strobe; TICK spacing = P*CLOCK_SIGNALS cycles.
REQ-028 The divider SHALL be cleared only by RES (not by START), so first-TICK latency SHALL lie in (P-1)*CLOCK_SIGNALS+1 .. P*CLOCK_SIGNALS cycles.
REQ-029 Without TIMER_BANK_PRESCALER_EN, no divider logic SHALL exist, every CLK SHALL be a step, CLOCK_SIGNALS SHALL be unused.

Verification
REQ-030 RES low 2 cycles, then START[0] without LOAD -> TICK=0, BUSY=0 for 20 cycles.
REQ-031 WIDTH=8, LOAD[0] PERIOD=5 MODE=1, START[0] -> TICK[0] at +5,+10,+15 cycles, BUSY[0]=1 throughout.
REQ-032 LOAD[1] PERIOD=3 MODE=0, START[1] -> single TICK[1] at +3, BUSY[1]=0 from +4, no further TICK in 20 cycles.
REQ-033 ch2 running PERIOD=4, START[2]+STOP[2] same cycle at +2 -> no TICK[2], BUSY[2]=0; then LOAD[2] PERIOD=0 -> period still 4 on restart.
REQ-034 ch0 running PERIOD=10, LOAD[0] PERIOD=2 at +4 -> next TICK[0] 2 cycles later, then every 2.
REQ-035 TIMER_BANK_PRESCALER_EN defined, CLOCK_SIGNALS=10, PERIOD=3 periodic -> TICK[0] spacing exactly 30 CLK cycles.
